// File: rtl/regfile.sv
// regfile: D = 2**AW entry by N-bit register file with one write port and two
// registered read ports sharing a read enable. Synchronous active-high reset
// and a synchronous clear both zero the whole array.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-edge write or
// clear onto the read ports; left undefined, reads return pre-edge contents.
module regfile #(
    parameter int N  = 16,
    parameter int AW = 3
) (
    input  logic          in_clk,
    input  logic          in_reset,
    input  logic          in_we,
    input  logic [0:AW-1] in_waddr,
    input  logic [0:N-1]  in_wdata,
    input  logic          in_re,
    input  logic [0:AW-1] in_raddr_a,
    input  logic [0:AW-1] in_raddr_b,
    input  logic          in_clear,
    output logic [0:N-1]  out_rdata_a,
    output logic [0:N-1]  out_rdata_b,
    output logic          out_rvalid
);

    localparam int D = 1 << AW;

    logic [0:N-1] mem [0:D-1];
    logic [0:N-1] read_a;
    logic [0:N-1] read_b;

    // Value each read port captures this edge: stored contents, or forwarded write/clear
    always_comb begin
        read_a = mem[in_raddr_a];
        read_b = mem[in_raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (in_clear) begin
            read_a = '0;
            read_b = '0;
        end else if (in_we) begin
            if (in_waddr == in_raddr_a) begin
                read_a = in_wdata;
            end
            if (in_waddr == in_raddr_b) begin
                read_b = in_wdata;
            end
        end
`endif
    end

    // Storage array: reset or clear zero every entry and swallow a coincident write
    always_ff @(posedge in_clk) begin
        if (in_reset || in_clear) begin
            for (int i = 0; i < D; i++) begin
                mem[i] <= '0;
            end
        end else if (in_we) begin
            mem[in_waddr] <= in_wdata;
        end
    end

    // Read output registers: capture on read enable, otherwise hold data and drop valid
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            out_rdata_a <= '0;
            out_rdata_b <= '0;
            out_rvalid  <= 1'b0;
        end else begin
            out_rvalid <= in_re;
            if (in_re) begin
                out_rdata_a <= read_a;
                out_rdata_b <= read_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: drives a default 16x8 instance and a narrow 8-bit x 4 instance
// with the same stimulus. A behavioural model predicts each cycle's outputs and
// queues them; per-instance monitors pop and compare after every clock edge.
module tb_regfile;

    typedef struct packed {
        logic        v;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic clk;

    // Wide instance (N=16, AW=3)
    logic        reset0, we0, re0, clear0;
    logic [0:2]  waddr0, raddr_a0, raddr_b0;
    logic [0:15] wdata0, rdata_a0, rdata_b0;
    logic        rvalid0;

    // Narrow instance (N=8, AW=2)
    logic        reset1, we1, re1, clear1;
    logic [0:1]  waddr1, raddr_a1, raddr_b1;
    logic [0:7]  wdata1, rdata_a1, rdata_b1;
    logic        rvalid1;

    int checks   = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [15:0] modelMem [2][8];
    logic [15:0] heldA [2];
    logic [15:0] heldB [2];

    regfile #(.N(16), .AW(3)) dut0 (
        .in_clk(clk), .in_reset(reset0), .in_we(we0), .in_waddr(waddr0),
        .in_wdata(wdata0), .in_re(re0), .in_raddr_a(raddr_a0),
        .in_raddr_b(raddr_b0), .in_clear(clear0), .out_rdata_a(rdata_a0),
        .out_rdata_b(rdata_b0), .out_rvalid(rvalid0)
    );

    regfile #(.N(8), .AW(2)) dut1 (
        .in_clk(clk), .in_reset(reset1), .in_we(we1), .in_waddr(waddr1),
        .in_wdata(wdata1), .in_re(re1), .in_raddr_a(raddr_a1),
        .in_raddr_b(raddr_b1), .in_clear(clear1), .out_rdata_a(rdata_a1),
        .out_rdata_b(rdata_b1), .out_rvalid(rvalid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what one clock edge does to a register file with the given depth/width
    function automatic exp_t modelEdge(input int inst, input int amask, input logic [15:0] dmask,
                                       input bit rst, input bit clr, input bit we, input int wa,
                                       input logic [15:0] wd, input bit re, input int ra, input int rb);
        exp_t e;
        int a = wa & amask;
        int pa = ra & amask;
        int pb = rb & amask;
        logic [15:0] d = wd & dmask;
        e = '0;
        if (rst) begin
            for (int i = 0; i < 8; i++) modelMem[inst][i] = 16'h0;
            heldA[inst] = 16'h0;
            heldB[inst] = 16'h0;
            return e;
        end
        if (re) begin
`ifdef REGFILE_BYPASS_EN
            heldA[inst] = clr ? 16'h0 : ((we && a == pa) ? d : modelMem[inst][pa]);
            heldB[inst] = clr ? 16'h0 : ((we && a == pb) ? d : modelMem[inst][pb]);
`else
            heldA[inst] = modelMem[inst][pa];
            heldB[inst] = modelMem[inst][pb];
`endif
        end
        if (clr) begin
            for (int i = 0; i < 8; i++) modelMem[inst][i] = 16'h0;
        end else if (we) begin
            modelMem[inst][a] = d;
        end
        e.v = re;
        e.a = heldA[inst];
        e.b = heldB[inst];
        return e;
    endfunction

    // Drive one cycle of inputs on both instances and queue the predicted outputs
    task automatic applyStimulus(input bit rst, input bit clr, input bit we, input int wa,
                                 input logic [15:0] wd, input bit re, input int ra, input int rb);
        @(negedge clk);
        reset0 = rst; clear0 = clr; we0 = we; re0 = re;
        waddr0 = 3'(wa); wdata0 = wd; raddr_a0 = 3'(ra); raddr_b0 = 3'(rb);
        reset1 = rst; clear1 = clr; we1 = we; re1 = re;
        waddr1 = 2'(wa & 3); wdata1 = wd[7:0]; raddr_a1 = 2'(ra & 3); raddr_b1 = 2'(rb & 3);
        q0.push_back(modelEdge(0, 7, 16'hFFFF, rst, clr, we, wa, wd, re, ra, rb));
        q1.push_back(modelEdge(1, 3, 16'h00FF, rst, clr, we, wa, wd, re, ra, rb));
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Monitor for the wide instance
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checkOutput("w_rvalid", 16'(rvalid0), 16'(e.v));
            checkOutput("w_rdata_a", rdata_a0, e.a);
            checkOutput("w_rdata_b", rdata_b0, e.b);
        end
    end

    // Monitor for the narrow instance
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput("n_rvalid", 16'(rvalid1), 16'(e.v));
            checkOutput("n_rdata_a", 16'(rdata_a1), e.a);
            checkOutput("n_rdata_b", 16'(rdata_b1), e.b);
        end
    end

    initial begin
        reset0 = 1'b1; clear0 = 1'b0; we0 = 1'b0; re0 = 1'b0;
        waddr0 = '0; wdata0 = '0; raddr_a0 = '0; raddr_b0 = '0;
        reset1 = 1'b1; clear1 = 1'b0; we1 = 1'b0; re1 = 1'b0;
        waddr1 = '0; wdata1 = '0; raddr_a1 = '0; raddr_b1 = '0;

        // Reset, then read addresses 0 and 7 from a freshly zeroed array
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 0, 7);

        // Write then read the same entry on both ports, then hold with re low
        applyStimulus(0, 0, 1, 3, 16'hBEEF, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 3, 3);
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 1, 2);

        // Same-edge write and read of entry 5, then a plain read
        applyStimulus(0, 0, 1, 5, 16'h1234, 0, 0, 0);
        applyStimulus(0, 0, 1, 5, 16'hABCD, 1, 5, 3);
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 5, 5);

        // Fill all entries, clear alongside a write and a read, then read everything back
        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 1, k, 16'(16'h1111 * k), 0, 0, 0);
        applyStimulus(0, 1, 1, 2, 16'hFFFF, 1, 2, 6);
        for (int k = 0; k < 8; k += 2) applyStimulus(0, 0, 0, 0, 16'h0, 1, k, k + 1);

        // Reset swallows a coincident write and read
        applyStimulus(0, 0, 1, 1, 16'h7777, 1, 1, 4);
        applyStimulus(1, 0, 1, 1, 16'h5555, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 1, 0);

        // Narrow instance: 0xA5 at address 3, all four entries written then read
        applyStimulus(0, 0, 1, 3, 16'h00A5, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 3, 3);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, k, 16'(16'h0C30 + k), 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 2, 3);

        // Randomized traffic with occasional clear and reset
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                          16'($urandom), $urandom_range(0, 2) != 0,
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("w_queue_drained", 16'(q0.size()), 16'h0);
        checkOutput("n_queue_drained", 16'(q1.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
